// File: rtl/srp16_pkg.sv
// Shared definitions for the 16-bit stack controller: op encodings, FSM states, SP default.
package srp16_pkg;

    typedef enum logic [1:0] {
        OpClear = 2'b00,
        OpPush  = 2'b01,
        OpPop   = 2'b10,
        OpPeek  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StResp
    } state_e;

    localparam logic [15:0] SpBaseDefault = 16'hFFFF;

    // Address of the top word for a downward-growing stack, modulo 2^16.
    function automatic logic [15:0] sp_from_count(input logic [15:0] base,
                                                  input logic [15:0] cnt);
        return base - cnt + 16'd1;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x 16, one synchronous write port and one synchronous read port, no reset.
module stack_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_ctrl.sv
// Request/response stack controller: push/pop/peek/clear over a synchronous RAM,
// one request per three cycles, with overflow/underflow reported on err.
module stack_ctrl
    import srp16_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter logic [15:0] SP_BASE = SpBaseDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  op,
    input  logic [15:0] din,
    output logic        resp_valid,
    output logic [15:0] dout,
    output logic        err,
    output logic [15:0] sp_out,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    op_e           op_q, op_d;
    logic [15:0]   din_q, din_d;
    logic [15:0]   dout_q, dout_d;
    logic          err_q, err_d;
    logic          load_q, load_d;

    logic          accept;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [15:0]   ram_rdata;

    assign req_ready  = (state_q == StIdle);
    assign accept     = req_valid && req_ready;
    assign full       = (count_q == DepthCnt);
    assign empty      = (count_q == '0);
    assign sp_out     = sp_from_count(SP_BASE, 16'(count_q));
    assign resp_valid = (state_q == StResp);
    assign err        = resp_valid && err_q;
    // RAM read data lands in RESP, so present it directly while dout_q catches up.
    assign dout       = (resp_valid && load_q) ? ram_rdata : dout_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        din_d     = din_q;
        dout_d    = dout_q;
        err_d     = err_q;
        load_d    = load_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = count_q[AW-1:0];
        ram_raddr = AW'(count_q - 1'b1);

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = op_e'(op);
                    din_d   = din;
                    err_d   = 1'b0;
                    load_d  = 1'b0;
                    state_d = StResp;
                    case (op_e'(op))
                        OpClear: count_d = '0;
                        OpPush: begin
                            if (full) err_d = 1'b1;
                            else      state_d = StWrite;
                        end
                        default: begin
                            if (empty) err_d = 1'b1;
                            else       state_d = StRead;
                        end
                    endcase
                end
            end
            StWrite: begin
                ram_we  = 1'b1;
                count_d = count_q + 1'b1;
                state_d = StResp;
            end
            StRead: begin
                ram_re = 1'b1;
                load_d = 1'b1;
                if (op_q == OpPop) begin
                    count_d = count_q - 1'b1;
                end
                state_d = StResp;
            end
            StResp: begin
                if (load_q) begin
                    dout_d = ram_rdata;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= '0;
            op_q    <= OpClear;
            din_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    stack_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (din_q),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl (DEPTH=4): a reference stack model predicts each response.
module tb_stack_ctrl;

    localparam int unsigned Depth = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  op = 2'b00;
    logic [15:0] din = 16'h0;
    logic        resp_valid;
    logic [15:0] dout;
    logic        err;
    logic [15:0] sp_out;
    logic        full;
    logic        empty;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] exp_q[$];  // {err, dout}
    logic [15:0] mstack[$];
    logic [15:0] mdout = 16'h0;

    always #5 clk = ~clk;

    stack_ctrl #(
        .DEPTH   (Depth),
        .SP_BASE (16'hFFFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .din        (din),
        .resp_valid (resp_valid),
        .dout       (dout),
        .err        (err),
        .sp_out     (sp_out),
        .full       (full),
        .empty      (empty)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("resp_err", 32'(err), 32'(e[16]));
                check("resp_dout", 32'(dout), 32'(e[15:0]));
            end
        end
    end

    task automatic check_status(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'(mstack.size() == 0));
        check({tag, "_full"}, 32'(full), 32'(mstack.size() == Depth));
        check({tag, "_sp"}, 32'(sp_out), 32'(16'(16'hFFFF - 16'(mstack.size()) + 16'd1)));
    endtask

    // Model predicts the response, then the request is driven and its latency measured.
    task automatic send(input logic [1:0] op_v, input logic [15:0] d);
        logic e_err;
        int   e_lat;
        int   lat;
        int   guard;
        e_err = 1'b0;
        e_lat = 2;
        case (op_v)
            2'b00: begin mstack.delete(); e_lat = 1; end
            2'b01: begin
                if (mstack.size() == Depth) begin e_err = 1'b1; e_lat = 1; end
                else mstack.push_back(d);
            end
            2'b10: begin
                if (mstack.size() == 0) begin e_err = 1'b1; e_lat = 1; end
                else mdout = mstack.pop_back();
            end
            default: begin
                if (mstack.size() == 0) begin e_err = 1'b1; e_lat = 1; end
                else mdout = mstack[$];
            end
        endcase
        exp_q.push_back({e_err, mdout});

        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        op = op_v;
        din = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op = ~op_v;  // busy-time changes must be ignored
        din = 16'($urandom);
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        check("latency", 32'(lat), 32'(e_lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check_status("rst");
        @(negedge clk);
        reset = 1'b1;

        // Single push: sp points at base.
        send(2'b01, 16'h0303);
        check("push1_sp", 32'(sp_out), 32'h0000FFFF);
        check_status("push1");

        // LIFO order.
        send(2'b01, 16'h1234);
        send(2'b10, 16'h0);
        send(2'b10, 16'h0);
        check("pop2_sp", 32'(sp_out), 32'h00000000);
        check_status("pop2");

        // Peek leaves count alone.
        send(2'b01, 16'hABCD);
        send(2'b11, 16'h0);
        send(2'b11, 16'h0);
        check("peek_sp", 32'(sp_out), 32'h0000FFFF);
        send(2'b10, 16'h0);

        // Overflow on the fifth push, then drain and underflow.
        for (int i = 0; i < 5; i++) begin
            send(2'b01, 16'(16'hA000 + i));
            check_status("fill");
        end
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_sp", 32'(sp_out), 32'h0000FFFC);
        for (int i = 0; i < 5; i++) begin
            send(2'b10, 16'h0);
            check_status("drain");
        end

        // Clear.
        for (int i = 0; i < 3; i++) send(2'b01, 16'(16'h5500 + i));
        send(2'b00, 16'h0);
        check_status("clear");
        send(2'b10, 16'h0);

        // Reset asserted in the WRITE cycle aborts the push.
        @(negedge clk);
        req_valid = 1'b1;
        op = 2'b01;
        din = 16'h1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        mstack.delete();
        mdout = 16'h0;
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        check_status("abort");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("release_ready", 32'(req_ready), 32'd1);
        send(2'b10, 16'h0);
        check_status("post_abort");

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
